debounce_filter: RTL and testbench

- Counter-based debounce filter for mechanical button/switch inputs.
- Sits directly downstream of the 2-FF input synchronizer and consumes its already-synchronized level. This block performs no metastability handling of its own.
- Output changes only after the input holds a new value for STABLE_CYCLES consecutive samples.
- Emits a clean level, single-cycle rise/fall pulses, and a single-cycle long-press pulse.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_filter.sv | 141 ++++++++++++++
 tb/tb_debounce_filter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default cycle constants for the button debounce filter.
package debounce_pkg;

    localparam int unsigned DEF_STABLE_CYCLES = 4;
    localparam int unsigned DEF_LONG_CYCLES   = 20;
    localparam int unsigned DEF_CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

endpackage : debounce_pkg

// File: rtl/debounce_filter.sv
// Counter-based debounce of an already-synchronized button level, with
// registered level, rise/fall pulses and a one-shot long-press pulse.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_long
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > CNT_MAX) begin : g_bad_stable
        $error("debounce_filter: STABLE_CYCLES out of range 1..2**CNT_W-1");
    end
    if (LONG_CYCLES < 1 || LONG_CYCLES > CNT_MAX) begin : g_bad_long
        $error("debounce_filter: LONG_CYCLES out of range 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX    = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] stab_cnt, stab_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic             level_nxt, rise_nxt, fall_nxt, long_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_LOW;
            stab_cnt <= '0;
            hold_cnt <= '0;
            o_level  <= 1'b0;
            o_rise   <= 1'b0;
            o_fall   <= 1'b0;
            o_long   <= 1'b0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_nxt;
            hold_cnt <= hold_nxt;
            o_level  <= level_nxt;
            o_rise   <= rise_nxt;
            o_fall   <= fall_nxt;
            o_long   <= long_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stab_nxt  = stab_cnt;
        hold_nxt  = hold_cnt;
        level_nxt = o_level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        long_nxt  = 1'b0;

        // Hold time accrues while the debounced level is high; the pulse
        // fires on the single step that reaches saturation.
        if (o_level && hold_cnt != LONG_MAX) begin
            hold_nxt = hold_cnt + CNT_ONE;
            long_nxt = (hold_cnt == LONG_LAST);
        end

        case (state)
            ST_LOW: begin
                if (i_level) begin
                    if (stab_cnt == STABLE_LAST) begin
                        state_nxt = ST_HIGH;
                        stab_nxt  = '0;
                        level_nxt = 1'b1;
                        rise_nxt  = 1'b1;
                        hold_nxt  = '0;
                    end else begin
                        state_nxt = ST_WAIT_HIGH;
                        stab_nxt  = CNT_ONE;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (!i_level) begin
                    state_nxt = ST_LOW;
                    stab_nxt  = '0;
                end else if (stab_cnt == STABLE_LAST) begin
                    state_nxt = ST_HIGH;
                    stab_nxt  = '0;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                    hold_nxt  = '0;
                end else begin
                    stab_nxt = stab_cnt + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!i_level) begin
                    if (stab_cnt == STABLE_LAST) begin
                        state_nxt = ST_LOW;
                        stab_nxt  = '0;
                        level_nxt = 1'b0;
                        fall_nxt  = 1'b1;
                        hold_nxt  = '0;
                        long_nxt  = 1'b0;
                    end else begin
                        state_nxt = ST_WAIT_LOW;
                        stab_nxt  = CNT_ONE;
                    end
                end
            end
            ST_WAIT_LOW: begin
                if (i_level) begin
                    state_nxt = ST_HIGH;
                    stab_nxt  = '0;
                end else if (stab_cnt == STABLE_LAST) begin
                    // A fall coinciding with the long-press step suppresses it.
                    state_nxt = ST_LOW;
                    stab_nxt  = '0;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                    hold_nxt  = '0;
                    long_nxt  = 1'b0;
                end else begin
                    stab_nxt = stab_cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_LOW;
                stab_nxt  = '0;
            end
        endcase
    end

endmodule : debounce_filter

// File: tb/tb_debounce_filter.sv
// Scoreboard bench for debounce_filter: a sample-history reference model
// queues expected outputs per edge; a monitor compares after each edge.
module tb_debounce_filter;

    localparam int unsigned S = 4;
    localparam int unsigned L = 20;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic i_level;
    logic o_level, o_rise, o_fall, o_long;

    always #5 clk = ~clk;

    debounce_filter #(
        .STABLE_CYCLES(S),
        .LONG_CYCLES  (L),
        .CNT_W        (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_level(i_level),
        .o_level(o_level),
        .o_rise (o_rise),
        .o_fall (o_fall),
        .o_long (o_long)
    );

    logic [3:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference: level flips once S consecutive samples disagree with it;
    // long press is "exactly L edges after the latest rise, still high".
    logic m_level;
    int   m_run;
    int   m_edge;
    int   m_rise_edge;

    function automatic logic [3:0] model_step(input logic r, input logic v);
        logic rise, fall, lng;
        rise = 1'b0;
        fall = 1'b0;
        lng  = 1'b0;
        if (!r) begin
            m_level     = 1'b0;
            m_run       = 0;
            m_edge      = 0;
            m_rise_edge = -100000;
        end else begin
            m_edge = m_edge + 1;
            if (v != m_level) m_run = m_run + 1;
            else              m_run = 0;
            if (m_run >= int'(S)) begin
                m_level = v;
                m_run   = 0;
                if (v) begin
                    rise        = 1'b1;
                    m_rise_edge = m_edge;
                end else begin
                    fall = 1'b1;
                end
            end
            if (m_level && (m_edge - m_rise_edge) == int'(L)) lng = 1'b1;
        end
        return {m_level, rise, fall, lng};
    endfunction

    task automatic drive(input logic r, input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n   = r;
            i_level = v;
            exp_q.push_back(model_step(r, v));
        end
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks = checks + 1;
                if ({o_level, o_rise, o_fall, o_long} !== e) begin
                    errors = errors + 1;
                    $display("FAIL outputs cycle %0d got level/rise/fall/long=%b required %b",
                             cyc, {o_level, o_rise, o_fall, o_long}, e);
                end
            end
        end
    end

    initial begin : stimulus
        logic v;
        int   len;
        rst_n   = 1'b0;
        i_level = 1'b0;
        void'(model_step(1'b0, 1'b0));

        // Reset held with a toggling input, then a quiet low period.
        for (int i = 0; i < 6; i++) drive(1'b0, 1'((i % 2)), 1);
        drive(1'b1, 1'b0, 50);

        // Clean press, long press, then long hold with no repeat.
        drive(1'b1, 1'b1, 30);
        drive(1'b1, 1'b1, 100);

        // Short release glitch, then a real release.
        drive(1'b1, 1'b0, 3);
        drive(1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, 4);
        drive(1'b1, 1'b0, 10);

        // Bounce during press: 1,1,1,0 then four 1s.
        drive(1'b1, 1'b1, 3);
        drive(1'b1, 1'b0, 1);
        drive(1'b1, 1'b1, 4);
        drive(1'b1, 1'b0, 10);

        // Fall landing on the long-press cycle.
        drive(1'b1, 1'b1, int'(L));
        drive(1'b1, 1'b0, int'(S));
        drive(1'b1, 1'b0, 6);

        // Reset mid-wait, then a fresh full run is needed.
        drive(1'b1, 1'b1, 3);
        drive(1'b0, 1'b1, 2);
        drive(1'b1, 1'b1, 4);
        drive(1'b1, 1'b0, 8);

        // Randomized segments: bouncy short runs, long holds, sporadic resets.
        repeat (200) begin
            v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) begin
                drive(1'b0, v, int'($urandom_range(1, 3)));
            end else begin
                if ($urandom_range(0, 3) == 0) len = int'($urandom_range(15, 26));
                else                           len = int'($urandom_range(1, 6));
                drive(1'b1, v, len);
            end
        end

        @(posedge clk);
        #3;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain got %0d pending entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_debounce_filter
